tower_loader: RTL and testbench
===============================

TOWER_LOADER -- requirements
Module: tower_loader

Interface
REQ-001 SHALL have parameter NUM_TOWERS, default 1024, meaning the maximum number of towers stored per event per bank.
REQ-002 SHALL have parameter ET_W, default 8, meaning the width of each of the eta, phi, et and e fields.
REQ-003 SHALL have ports, listed as name, direction, width, meaning:
- clk, in, 1: the single clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input tower present.
- in_ready, out, 1: loader can accept a tower.
- in_last, in, 1: the current tower is the last of its event.
- in_eta, in_phi, in_et, in_e, in, ET_W each: tower fields.
- et_threshold, in, ET_W: zero-suppression threshold.
- ev_valid, out, 1: a complete event is available to the ordinality stage.
- ev_done, in, 1: the consumer releases the current event; single-cycle pulse.
- ev_count, out, clog2(NUM_TOWERS+1): number of towers stored in the presented event.
- ev_overflow, out, 1: the presented event exceeded NUM_TOWERS.
- rd_addr, in, clog2(NUM_TOWERS): read index.
- rd_eta, rd_phi, rd_et, rd_e, out, ET_W each: tower data at rd_addr.

Function
REQ-004 SHALL double-buffer using two banks, with a write-bank pointer wp and a read-bank pointer rp, plus per-bank state EMPTY, FILLING or FULL.
REQ-005 SHALL drive in_ready = 1 when bank[wp] is not FULL.
- A tower is accepted when in_valid && in_ready.
REQ-006 SHALL store an accepted tower at index wcount of bank[wp] only if in_et >= et_threshold and wcount < NUM_TOWERS, then increment wcount.
- Towers below the threshold are consumed but not stored.
REQ-007 SHALL set the sticky overflow flag of bank[wp] when an accepted, above-threshold tower arrives while wcount == NUM_TOWERS.
- That tower is discarded.
REQ-008 SHALL handle an accepted tower with in_last = 1 as follows:
- store it per REQ-006;
- mark bank[wp] FULL and latch its count, counting this tower if it was stored;
- toggle wp;
- clear wcount and the new bank's overflow flag.
- The bank transitions EMPTY to FILLING on the first accepted tower and FILLING to FULL on in_last.
- A lone tower with in_last = 1 goes EMPTY to FULL directly.
REQ-009 SHALL assert ev_valid while bank[rp] is FULL.
- ev_count and ev_overflow reflect bank[rp].
REQ-010 SHALL, on ev_done while ev_valid, set bank[rp] to EMPTY and toggle rp.
- ev_done while ev_valid = 0 is ignored.
REQ-011 SHALL return bank[rp] data at rd_addr with 1-cycle registered latency.
- rd_addr >= ev_count returns undefined-but-stable data; the consumer bounds reads by ev_count.
REQ-012 SHALL support in_last completing bank[wp] in the same cycle as ev_done releasing bank[rp] (the other bank), with both updates taking effect.
REQ-013 SHALL accept one tower per cycle with zero bubbles while the opposite bank is EMPTY.
REQ-014 SHALL treat an event with zero stored towers as valid: ev_valid = 1 and ev_count = 0.

Reset
REQ-015 SHALL on rst set wp = rp = 0, both banks EMPTY, wcount = 0, and overflow flags = 0.
- Outputs then read in_ready = 1, ev_valid = 0, ev_count = 0, ev_overflow = 0, rd_* = 0.
REQ-016 SHALL abandon any partially filled event when rst is asserted mid-event.
- Bank contents need not be cleared.

Configuration
REQ-017 SHALL, when TOWER_LOADER_STATS_EN is defined, add two outputs:
- stat_events (32 bit): completed events;
- stat_dropped (32 bit): towers discarded by threshold or overflow.
- Both clear on rst and saturate at all-ones.
- Without the macro, these ports and counters SHALL NOT exist.

Structure
REQ-018 SHALL take ET_W, the tower record typedef (eta, phi, et, e) and the bank-state enum from shared package collider_pkg.
REQ-019 SHALL instantiate sub-module tower_bank twice.
- tower_bank is one NUM_TOWERS-deep write-port/registered-read-port storage.

Verification
REQ-020 Threshold: et_threshold = 10, 4 towers with et = 5, 10, 200, 9 (last on the 4th) -> ev_valid, ev_count = 2, reads return et 10 and 200 at addr 0 and 1.
REQ-021 Overflow: NUM_TOWERS = 4, 6 towers above threshold -> ev_count = 4, ev_overflow = 1, stat_dropped = 2 with STATS_EN.
REQ-022 Back-pressure: two events loaded with no ev_done -> in_ready = 0 after the second in_last; ev_done -> in_ready = 1 the next cycle.
REQ-023 Simultaneous: in_last on bank 1 in the same cycle as ev_done on bank 0 -> ev_valid stays 1, ev_count switches to bank 1's count.
REQ-024 Reset mid-event: 3 towers without last, then rst -> ev_valid = 0, and the next event's ev_count excludes those 3.
REQ-025 Empty event: a single tower with et = 0, threshold = 1, last = 1 -> ev_valid = 1, ev_count = 0.

Source files
------------

// File: rtl/collider_pkg.sv
// Shared tower record, field width and bank-state encoding for the collider
// front-end blocks.
package collider_pkg;

    localparam int ET_W = 8;

    typedef struct packed {
        logic [ET_W-1:0] eta;
        logic [ET_W-1:0] phi;
        logic [ET_W-1:0] et;
        logic [ET_W-1:0] e;
    } tower_t;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

endpackage

// File: rtl/tower_bank.sv
// One event's worth of tower storage: single write port, registered read port.
module tower_bank
    import collider_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  tower_t        wdata_i,
    input  logic [AW-1:0] raddr_i,
    output tower_t        rdata_o
);

    tower_t mem_q [DEPTH];
    tower_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is reset so that read data is zero out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tower_loader.sv
// Double-buffered, zero-suppressing tower loader feeding the ordinality stage.
// Optional statistics outputs are enabled by defining TOWER_LOADER_STATS_EN.
module tower_loader #(
    parameter int NUM_TOWERS = 1024,
    parameter int ET_W       = collider_pkg::ET_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_last,
    input  logic [ET_W-1:0]                   in_eta,
    input  logic [ET_W-1:0]                   in_phi,
    input  logic [ET_W-1:0]                   in_et,
    input  logic [ET_W-1:0]                   in_e,
    input  logic [ET_W-1:0]                   et_threshold,
    output logic                              ev_valid,
    input  logic                              ev_done,
    output logic [$clog2(NUM_TOWERS+1)-1:0]   ev_count,
    output logic                              ev_overflow,
    input  logic [$clog2(NUM_TOWERS)-1:0]     rd_addr,
    output logic [ET_W-1:0]                   rd_eta,
    output logic [ET_W-1:0]                   rd_phi,
    output logic [ET_W-1:0]                   rd_et,
    output logic [ET_W-1:0]                   rd_e
`ifdef TOWER_LOADER_STATS_EN
    ,
    output logic [31:0]                       stat_events,
    output logic [31:0]                       stat_dropped
`endif
);

    import collider_pkg::*;

    localparam int AW = $clog2(NUM_TOWERS);
    localparam int CW = $clog2(NUM_TOWERS + 1);

    bank_state_t   st_q   [2];
    logic [CW-1:0] cnt_q  [2];
    logic          ovf_q  [2];
    logic          wp_q;
    logic          rp_q;
    logic          rsel_q;
    logic [CW-1:0] wcount_q;

    logic   accept, above, room, store, drop_ovf, release_ev;
    tower_t wr_tower;
    tower_t rd_tower [2];

    assign in_ready   = (st_q[wp_q] != BANK_FULL);
    assign accept     = in_valid && in_ready;
    assign above      = (in_et >= et_threshold);
    assign room       = (wcount_q < CW'(NUM_TOWERS));
    assign store      = accept && above && room;
    assign drop_ovf   = accept && above && !room;
    assign release_ev = ev_done && (st_q[rp_q] == BANK_FULL);

    assign ev_valid    = (st_q[rp_q] == BANK_FULL);
    assign ev_count    = cnt_q[rp_q];
    assign ev_overflow = ovf_q[rp_q];

    // The write bank never equals a FULL read bank while accepting, so the
    // accept and release updates below always touch different banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q[0]  <= BANK_EMPTY;
            st_q[1]  <= BANK_EMPTY;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            ovf_q[0] <= 1'b0;
            ovf_q[1] <= 1'b0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            rsel_q   <= 1'b0;
            wcount_q <= '0;
        end else begin
            rsel_q <= rp_q;
            if (accept) begin
                // Overflow restarts with the bank's first tower rather than at
                // the toggle, so a still-presented event keeps its flag.
                ovf_q[wp_q] <= ((st_q[wp_q] == BANK_EMPTY) ? 1'b0 : ovf_q[wp_q]) | drop_ovf;
                if (in_last) begin
                    st_q[wp_q]  <= BANK_FULL;
                    cnt_q[wp_q] <= wcount_q + CW'(store);
                    wp_q        <= ~wp_q;
                    wcount_q    <= '0;
                end else begin
                    st_q[wp_q] <= BANK_FILLING;
                    wcount_q   <= wcount_q + CW'(store);
                end
            end
            if (release_ev) begin
                st_q[rp_q] <= BANK_EMPTY;
                rp_q       <= ~rp_q;
            end
        end
    end

    assign wr_tower = '{eta: in_eta, phi: in_phi, et: in_et, e: in_e};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tower_bank #(
            .DEPTH (NUM_TOWERS),
            .AW    (AW)
        ) u_bank (
            .clk_i   (clk),
            .rst_i   (rst),
            .we_i    (store && (wp_q == 1'(b))),
            .waddr_i (wcount_q[AW-1:0]),
            .wdata_i (wr_tower),
            .raddr_i (rd_addr),
            .rdata_o (rd_tower[b])
        );
    end

    assign rd_eta = rd_tower[rsel_q].eta;
    assign rd_phi = rd_tower[rsel_q].phi;
    assign rd_et  = rd_tower[rsel_q].et;
    assign rd_e   = rd_tower[rsel_q].e;

`ifdef TOWER_LOADER_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] stat_events_q, stat_dropped_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_events_q  <= '0;
            stat_dropped_q <= '0;
        end else begin
            if (accept && in_last) stat_events_q  <= sat_inc(stat_events_q);
            if (accept && !store)  stat_dropped_q <= sat_inc(stat_dropped_q);
        end
    end

    assign stat_events  = stat_events_q;
    assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: tb/tb_tower_loader.sv
// Directed bench for tower_loader with a 4-deep bank; stats checks are built
// only when TOWER_LOADER_STATS_EN is defined.
module tb_tower_loader;

    localparam int NT = 4;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_last;
    logic [W-1:0] in_eta, in_phi, in_et, in_e, et_threshold;
    logic         ev_valid, ev_done, ev_overflow;
    logic [2:0]   ev_count;
    logic [1:0]   rd_addr;
    logic [W-1:0] rd_eta, rd_phi, rd_et, rd_e;
`ifdef TOWER_LOADER_STATS_EN
    logic [31:0]  stat_events, stat_dropped;
`endif

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    tower_loader #(.NUM_TOWERS(NT), .ET_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .in_eta       (in_eta),
        .in_phi       (in_phi),
        .in_et        (in_et),
        .in_e         (in_e),
        .et_threshold (et_threshold),
        .ev_valid     (ev_valid),
        .ev_done      (ev_done),
        .ev_count     (ev_count),
        .ev_overflow  (ev_overflow),
        .rd_addr      (rd_addr),
        .rd_eta       (rd_eta),
        .rd_phi       (rd_phi),
        .rd_et        (rd_et),
        .rd_e         (rd_e)
`ifdef TOWER_LOADER_STATS_EN
        ,
        .stat_events  (stat_events),
        .stat_dropped (stat_dropped)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] et, input logic last);
        in_valid = 1'b1;
        in_eta   = et ^ 8'h5A;
        in_phi   = et + 8'd3;
        in_et    = et;
        in_e     = ~et;
        in_last  = last;
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        if (!in_ready) chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [W-1:0] et);
        rd_addr = a;
        tick();
        chk({tag, "_et"},  {24'd0, rd_et},  {24'd0, et});
        chk({tag, "_eta"}, {24'd0, rd_eta}, {24'd0, et ^ 8'h5A});
    endtask

    task automatic done_pulse();
        ev_done = 1'b1;
        tick();
        ev_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; ev_done = 1'b0;
        in_eta = '0; in_phi = '0; in_et = '0; in_e = '0;
        et_threshold = 8'd10; rd_addr = '0;
        do_reset();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_ev_count", {29'd0, ev_count}, 32'd0);
        chk("rst_ev_ovf",   {31'd0, ev_overflow}, 32'd0);
        chk("rst_rd_et",    {24'd0, rd_et}, 32'd0);

        // Threshold: only et 10 and 200 are kept.
        send(8'd5, 1'b0); send(8'd10, 1'b0); send(8'd200, 1'b0); send(8'd9, 1'b1);
        chk("thr_valid", {31'd0, ev_valid}, 32'd1);
        chk("thr_count", {29'd0, ev_count}, 32'd2);
        chk("thr_ovf",   {31'd0, ev_overflow}, 32'd0);
        rd_chk("thr_rd0", 2'd0, 8'd10);
        rd_chk("thr_rd1", 2'd1, 8'd200);
`ifdef TOWER_LOADER_STATS_EN
        chk("thr_stat_events",  stat_events,  32'd1);
        chk("thr_stat_dropped", stat_dropped, 32'd2);
`endif
        done_pulse();
        chk("thr_released", {31'd0, ev_valid}, 32'd0);

        // Overflow: 6 towers into a 4-deep bank.
        do_reset();
        et_threshold = 8'd1;
        for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
        chk("ovf_valid", {31'd0, ev_valid}, 32'd1);
        chk("ovf_count", {29'd0, ev_count}, 32'd4);
        chk("ovf_flag",  {31'd0, ev_overflow}, 32'd1);
        rd_chk("ovf_rd3", 2'd3, 8'd4);
`ifdef TOWER_LOADER_STATS_EN
        chk("ovf_stat_events",  stat_events,  32'd1);
        chk("ovf_stat_dropped", stat_dropped, 32'd2);
`endif
        done_pulse();

        // Back-pressure: two events, no release.
        send(8'd50, 1'b1);
        chk("bp_ready_one", {31'd0, in_ready}, 32'd1);
        chk("bp_ovf_clean", {31'd0, ev_overflow}, 32'd0);
        send(8'd60, 1'b0); send(8'd70, 1'b1);
        chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_count_a",    {29'd0, ev_count}, 32'd1);
        rd_chk("bp_rd_a", 2'd0, 8'd50);
        done_pulse();
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        chk("bp_valid_b",    {31'd0, ev_valid}, 32'd1);
        chk("bp_count_b",    {29'd0, ev_count}, 32'd2);

        // Simultaneous last on one bank and release of the other.
        send(8'd80, 1'b0); send(8'd85, 1'b0);
        in_valid = 1'b1; in_et = 8'd90; in_eta = 8'd90 ^ 8'h5A; in_phi = 8'd93;
        in_e = ~8'd90; in_last = 1'b1; ev_done = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0; ev_done = 1'b0;
        chk("sim_valid", {31'd0, ev_valid}, 32'd1);
        chk("sim_count", {29'd0, ev_count}, 32'd3);
        chk("sim_ready", {31'd0, in_ready}, 32'd1);
        rd_chk("sim_rd2", 2'd2, 8'd90);
        done_pulse();
        chk("sim_released", {31'd0, ev_valid}, 32'd0);

        // Reset mid-event discards the partial fill.
        send(8'd20, 1'b0); send(8'd30, 1'b0); send(8'd40, 1'b0);
        do_reset();
        chk("mid_valid", {31'd0, ev_valid}, 32'd0);
        chk("mid_ready", {31'd0, in_ready}, 32'd1);
        send(8'd55, 1'b1);
        chk("mid_count", {29'd0, ev_count}, 32'd1);
        rd_chk("mid_rd0", 2'd0, 8'd55);
        done_pulse();

        // Event with nothing stored is still presented.
        send(8'd0, 1'b1);
        chk("empty_valid", {31'd0, ev_valid}, 32'd1);
        chk("empty_count", {29'd0, ev_count}, 32'd0);
        chk("empty_ovf",   {31'd0, ev_overflow}, 32'd0);
        done_pulse();
        chk("empty_released", {31'd0, ev_valid}, 32'd0);

        // A release with nothing presented must not move the read pointer.
        done_pulse();
        send(8'd33, 1'b1);
        chk("stray_valid", {31'd0, ev_valid}, 32'd1);
        chk("stray_count", {29'd0, ev_count}, 32'd1);
        rd_chk("stray_rd0", 2'd0, 8'd33);
`ifdef TOWER_LOADER_STATS_EN
        chk("end_stat_events",  stat_events,  32'd3);
        chk("end_stat_dropped", stat_dropped, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
